// File: rtl/cmd_pkr_if.sv
// Command packer bus bundle: slave command/response side and master beat side.
// The slave modport is the packer's view; the master modport is the peer's view.
interface cmd_pkr_if;
    logic         i_slv_cmd_vld;
    logic         i_slv_cmd_rnw;
    logic [63:0]  i_slv_cmd_dat;
    logic         o_slv_rsp_vld;
    logic [63:0]  o_slv_rsp_dat;
    logic         o_mst_cmd_vld;
    logic         o_mst_cmd_sop;
    logic         o_mst_cmd_eop;
    logic [127:0] o_mst_cmd_dat;

    modport slave (
        input  i_slv_cmd_vld, i_slv_cmd_rnw, i_slv_cmd_dat,
        output o_slv_rsp_vld, o_slv_rsp_dat,
        output o_mst_cmd_vld, o_mst_cmd_sop, o_mst_cmd_eop, o_mst_cmd_dat
    );

    modport master (
        output i_slv_cmd_vld, i_slv_cmd_rnw, i_slv_cmd_dat,
        input  o_slv_rsp_vld, o_slv_rsp_dat,
        input  o_mst_cmd_vld, o_mst_cmd_sop, o_mst_cmd_eop, o_mst_cmd_dat
    );
endinterface

// File: rtl/cmd_pkr.sv
// Packs 64-bit write words into framed 128-bit beats through an 8-deep packet FIFO.
// Define CMD_PKR_STATS_EN to add the 32-bit emitted-packet counter in status [63:32].
module cmd_pkr (
    input  logic       clk,
    input  logic       arst_n,
    cmd_pkr_if.slave   bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    function automatic logic [4:0] beats_needed(input logic [4:0] len);
        logic [5:0] sum;
        sum = {1'b0, len} + 6'd1;
        return sum[5:1];
    endfunction

    logic [1:0]   state_r, state_nxt_s;
    logic [4:0]   rem_r, rem_nxt_s;
    logic         odd_r, odd_nxt_s;
    logic [63:0]  lo_r, lo_nxt_s;

    logic [128:0] mem_r [0:7];
    logic [2:0]   wr_ptr_r, rd_ptr_r;
    logic [3:0]   count_r, commit_cnt_r;
    logic         busy_r;
    logic [15:0]  drop_cnt_r;
    logic [31:0]  pkt_cnt_s;

    logic         mst_vld_r, mst_sop_r, mst_eop_r;
    logic [127:0] mst_dat_r;
    logic         rsp_vld_r;
    logic [63:0]  rsp_dat_r;

    logic         wr_s, rd_s, push_s, push_eop_s, drop_s, commit_s;
    logic         pop_s, pop_eop_s;
    logic [127:0] push_dat_s;
    logic [128:0] head_s;
    logic [4:0]   len_s;
    logic [3:0]   free_s;
    logic [63:0]  status_s;

    assign wr_s      = bus.i_slv_cmd_vld & ~bus.i_slv_cmd_rnw;
    assign rd_s      = bus.i_slv_cmd_vld &  bus.i_slv_cmd_rnw;
    assign len_s     = bus.i_slv_cmd_dat[4:0];
    assign free_s    = 4'd8 - count_r;
    assign commit_s  = push_s & push_eop_s;
    assign head_s    = mem_r[rd_ptr_r];
    // A committed packet is fully resident, so once started it drains without gaps.
    assign pop_s     = busy_r | (commit_cnt_r != 4'd0);
    assign pop_eop_s = pop_s & head_s[128];
    assign status_s  = {pkt_cnt_s, 8'd0, drop_cnt_r, 2'b00, busy_r,
                        (state_r != ST_IDLE), count_r};

    // Input FSM: header admission, word pairing and discard counting.
    always_comb begin
        state_nxt_s = state_r;
        rem_nxt_s   = rem_r;
        odd_nxt_s   = odd_r;
        lo_nxt_s    = lo_r;
        push_s      = 1'b0;
        push_eop_s  = 1'b0;
        push_dat_s  = 128'd0;
        drop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wr_s) begin
                    if ((len_s == 5'd0) || (beats_needed(len_s) > {1'b0, free_s})) begin
                        drop_s = 1'b1;
                        if (len_s > 5'd1) begin
                            state_nxt_s = ST_DISCARD;
                            rem_nxt_s   = len_s - 5'd1;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else if (len_s == 5'd1) begin
                        push_s     = 1'b1;
                        push_eop_s = 1'b1;
                        push_dat_s = {64'd0, bus.i_slv_cmd_dat};
                    end else begin
                        state_nxt_s = ST_COLLECT;
                        rem_nxt_s   = len_s - 5'd1;
                        lo_nxt_s    = bus.i_slv_cmd_dat;
                        odd_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (wr_s) begin
                    rem_nxt_s = rem_r - 5'd1;
                    odd_nxt_s = ~odd_r;
                    if (odd_r) begin
                        push_s     = 1'b1;
                        push_eop_s = (rem_r == 5'd1);
                        push_dat_s = {bus.i_slv_cmd_dat, lo_r};
                    end else if (rem_r == 5'd1) begin
                        push_s     = 1'b1;
                        push_eop_s = 1'b1;
                        push_dat_s = {64'd0, bus.i_slv_cmd_dat};
                    end else begin
                        lo_nxt_s = bus.i_slv_cmd_dat;
                    end
                    if (rem_r == 5'd1) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_COLLECT;
                    end
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_DISCARD: begin
                if (wr_s) begin
                    rem_nxt_s = rem_r - 5'd1;
                    if (rem_r == 5'd1) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DISCARD;
                    end
                end else begin
                    state_nxt_s = ST_DISCARD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Input FSM and packing registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= ST_IDLE;
            rem_r   <= 5'd0;
            odd_r   <= 1'b0;
            lo_r    <= 64'd0;
        end else begin
            state_r <= state_nxt_s;
            rem_r   <= rem_nxt_s;
            odd_r   <= odd_nxt_s;
            lo_r    <= lo_nxt_s;
        end
    end

    // FIFO storage; validity is carried entirely by the pointers and counts.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {push_eop_s, push_dat_s};
        end
    end

    // FIFO pointers, occupancy, committed-packet count, output progress, drop count.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_r     <= 3'd0;
            rd_ptr_r     <= 3'd0;
            count_r      <= 4'd0;
            commit_cnt_r <= 4'd0;
            busy_r       <= 1'b0;
            drop_cnt_r   <= 16'd0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + 3'd1;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + 3'd1;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
            case ({commit_s, pop_eop_s})
                2'b10:   commit_cnt_r <= commit_cnt_r + 4'd1;
                2'b01:   commit_cnt_r <= commit_cnt_r - 4'd1;
                default: commit_cnt_r <= commit_cnt_r;
            endcase
            if (pop_s) busy_r <= ~head_s[128];
            if (drop_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'd1;
        end
    end

`ifdef CMD_PKR_STATS_EN
    logic [31:0] pkt_cnt_r;

    // Emitted-packet counter, wrapping.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pkt_cnt_r <= 32'd0;
        end else if (pop_eop_s) begin
            pkt_cnt_r <= pkt_cnt_r + 32'd1;
        end
    end

    assign pkt_cnt_s = pkt_cnt_r;
`else
    assign pkt_cnt_s = 32'd0;
`endif

    // Registered master beat and slave response outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mst_vld_r <= 1'b0;
            mst_sop_r <= 1'b0;
            mst_eop_r <= 1'b0;
            mst_dat_r <= 128'd0;
            rsp_vld_r <= 1'b0;
            rsp_dat_r <= 64'd0;
        end else begin
            mst_vld_r <= pop_s;
            mst_sop_r <= pop_s & ~busy_r;
            mst_eop_r <= pop_eop_s;
            mst_dat_r <= pop_s ? head_s[127:0] : 128'd0;
            rsp_vld_r <= rd_s;
            if (rd_s) rsp_dat_r <= status_s;
        end
    end

    assign bus.o_mst_cmd_vld = mst_vld_r;
    assign bus.o_mst_cmd_sop = mst_sop_r;
    assign bus.o_mst_cmd_eop = mst_eop_r;
    assign bus.o_mst_cmd_dat = mst_dat_r;
    assign bus.o_slv_rsp_vld = rsp_vld_r;
    assign bus.o_slv_rsp_dat = rsp_dat_r;
endmodule

// File: tb/tb_cmd_pkr.sv
// Scoreboard bench for cmd_pkr: stimulus queues expected beats/responses, a monitor checks them.
module tb_cmd_pkr;
    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_pkr_if bus();
    cmd_pkr dut (.clk(clk), .arst_n(arst_n), .bus(bus));

`ifdef CMD_PKR_STATS_EN
    localparam logic [31:0] STATS = 32'd1;
`else
    localparam logic [31:0] STATS = 32'd0;
`endif

    typedef struct {
        logic         sop;
        logic         eop;
        logic [127:0] dat;
        int           cyc;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] rsp_q[$];
    logic [63:0] last_rsp = 64'd0;
    beat_t       mon_e;
    logic [63:0] mon_r;
    int cyc = 0, last_cyc = 0, n_chk = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] st(input logic [3:0] occ, input logic fsm, input logic busy,
                                       input logic [15:0] drop, input logic [31:0] pk);
        return {pk * STATS, 8'd0, drop, 2'b00, busy, fsm, occ};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic exp_beat(input logic s, input logic e, input logic [127:0] d, input int c);
        beat_t b;
        b.sop = s; b.eop = e; b.dat = d; b.cyc = c;
        exp_q.push_back(b);
    endtask

    task automatic wr(input logic [63:0] d);
        @(negedge clk);
        bus.i_slv_cmd_vld = 1'b1; bus.i_slv_cmd_rnw = 1'b0; bus.i_slv_cmd_dat = d;
        @(posedge clk); #1;
        bus.i_slv_cmd_vld = 1'b0; bus.i_slv_cmd_dat = 64'd0;
        last_cyc = cyc;
    endtask

    task automatic rd(input logic [63:0] e);
        @(negedge clk);
        rsp_q.push_back(e);
        bus.i_slv_cmd_vld = 1'b1; bus.i_slv_cmd_rnw = 1'b1; bus.i_slv_cmd_dat = 64'hDEAD_BEEF_0000_0003;
        @(posedge clk); #1;
        bus.i_slv_cmd_vld = 1'b0; bus.i_slv_cmd_rnw = 1'b0; bus.i_slv_cmd_dat = 64'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Sends a len-word packet (header carries len); optionally queues its expected beats.
    task automatic send_pkt(input int len, input logic [63:0] base, input bit keep);
        logic [63:0] w [16];
        int nb;
        for (int i = 0; i < 16; i++) w[i] = base + (64'(i) * 64'h0101_0101_0000_0000);
        w[0] = {base[63:5], 5'(len)};
        for (int i = 0; i < len; i++) wr(w[i]);
        nb = (len + 1) / 2;
        if (keep) begin
            for (int j = 0; j < nb; j++)
                exp_beat(j == 0, j == nb - 1,
                         {((2 * j + 1) < len) ? w[2 * j + 1] : 64'd0, w[2 * j]},
                         last_cyc + 1 + j);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a beat or a response.
    always @(negedge clk) begin
        if (arst_n) begin
            if (bus.o_mst_cmd_vld) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL beat: got unexpected beat dat=%h at cycle %0d, expected none",
                             bus.o_mst_cmd_dat, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.o_mst_cmd_sop !== mon_e.sop || bus.o_mst_cmd_eop !== mon_e.eop ||
                        bus.o_mst_cmd_dat !== mon_e.dat || cyc != mon_e.cyc) begin
                        n_err++;
                        $display("FAIL beat: got sop=%b eop=%b dat=%h cyc=%0d expected sop=%b eop=%b dat=%h cyc=%0d",
                                 bus.o_mst_cmd_sop, bus.o_mst_cmd_eop, bus.o_mst_cmd_dat, cyc,
                                 mon_e.sop, mon_e.eop, mon_e.dat, mon_e.cyc);
                    end
                end
            end
            if (bus.o_slv_rsp_vld) begin
                n_chk++;
                if (rsp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp: got unexpected response %h, expected none", bus.o_slv_rsp_dat);
                end else begin
                    mon_r = rsp_q.pop_front();
                    last_rsp = mon_r;
                    if (bus.o_slv_rsp_dat !== mon_r) begin
                        n_err++;
                        $display("FAIL rsp: got %h expected %h", bus.o_slv_rsp_dat, mon_r);
                    end
                end
            end else begin
                n_chk++;
                if (bus.o_slv_rsp_dat !== last_rsp) begin
                    n_err++;
                    $display("FAIL rsp_hold: got %h expected %h", bus.o_slv_rsp_dat, last_rsp);
                end
            end
        end
    end

    initial begin
        bus.i_slv_cmd_vld = 1'b0;
        bus.i_slv_cmd_rnw = 1'b0;
        bus.i_slv_cmd_dat = 64'd0;
        idle(3); #1;
        chk("rst_mst_vld", 128'(bus.o_mst_cmd_vld), 128'd0);
        chk("rst_mst_sop_eop", 128'({bus.o_mst_cmd_sop, bus.o_mst_cmd_eop}), 128'd0);
        chk("rst_mst_dat", bus.o_mst_cmd_dat, 128'd0);
        chk("rst_rsp", 128'({bus.o_slv_rsp_vld, bus.o_slv_rsp_dat}), 128'd0);
        @(negedge clk) arst_n = 1'b1;
        idle(2);

        // LEN=3: header, A, B
        wr(64'h1234_5678_9ABC_DE03);
        wr(64'hAAAA_AAAA_1111_1111);
        wr(64'hBBBB_BBBB_2222_2222);
        exp_beat(1'b1, 1'b0, {64'hAAAA_AAAA_1111_1111, 64'h1234_5678_9ABC_DE03}, last_cyc + 1);
        exp_beat(1'b0, 1'b1, {64'd0, 64'hBBBB_BBBB_2222_2222}, last_cyc + 2);
        idle(4);
        rd(st(4'd0, 1'b0, 1'b0, 16'd0, 32'd1));

        // LEN=0 header is dropped
        wr(64'hFFFF_0000_0000_00E0);
        idle(3);
        rd(st(4'd0, 1'b0, 1'b0, 16'd1, 32'd1));

        // LEN=1: header-only packet
        wr(64'h0BAD_CAFE_0000_0021);
        exp_beat(1'b1, 1'b1, {64'd0, 64'h0BAD_CAFE_0000_0021}, last_cyc + 1);
        idle(3);

        // Two full packets, then one dropped while the FIFO is occupied, then a short one
        send_pkt(16, 64'h1000_0000_0000_0000, 1'b1);
        idle(10);
        send_pkt(16, 64'h2000_0000_00A0_0000, 1'b1);
        send_pkt(16, 64'h3000_0000_00B0_0000, 1'b0);
        send_pkt(2,  64'h4000_0000_00C0_0000, 1'b1);
        idle(12);
        rd(st(4'd0, 1'b0, 1'b0, 16'd2, 32'd5));

        // LEN=4 with a status read mid-packet
        wr(64'h4444_0000_0000_0004);
        wr(64'h5555_0000_0000_0001);
        wr(64'h5555_0000_0000_0002);
        rd(st(4'd1, 1'b1, 1'b0, 16'd2, 32'd5));
        wr(64'h5555_0000_0000_0003);
        exp_beat(1'b1, 1'b0, {64'h5555_0000_0000_0001, 64'h4444_0000_0000_0004}, last_cyc + 1);
        exp_beat(1'b0, 1'b1, {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002}, last_cyc + 2);
        idle(5);

        // Reset in the middle of a LEN=6 packet
        wr(64'h6666_0000_0000_0006);
        wr(64'h6666_0000_0000_00F1);
        @(negedge clk);
        arst_n = 1'b0;
        last_rsp = 64'd0;
        #1;
        chk("midrst_mst_vld", 128'(bus.o_mst_cmd_vld), 128'd0);
        chk("midrst_rsp_dat", 128'(bus.o_slv_rsp_dat), 128'd0);
        @(negedge clk) arst_n = 1'b1;
        idle(20);
        rd(st(4'd0, 1'b0, 1'b0, 16'd0, 32'd0));
        idle(3);

        // Odd LEN=5 after reset
        send_pkt(5, 64'h7000_0000_00D0_0000, 1'b1);
        idle(6);
        rd(st(4'd0, 1'b0, 1'b0, 16'd0, 32'd1));
        idle(5);

        chk("beats_left", 128'(exp_q.size()), 128'd0);
        chk("rsps_left", 128'(rsp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
